// File: rtl/fft_butterfly_r2x.sv
// fft_butterfly_r2x: pipelined radix-2 DIT/DIF complex butterfly with scaling, saturation and back-pressure
module fft_butterfly_r2x #(
  parameter int DATA_WIDTH    = 24,
  parameter int TWIDDLE_WIDTH = 24,
  parameter int TAG_WIDTH     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_valid,
  output logic                      o_in_ready,
  input  logic [2*DATA_WIDTH-1:0]   i_data_a,
  input  logic [2*DATA_WIDTH-1:0]   i_data_b,
  input  logic [2*TWIDDLE_WIDTH-1:0] i_twiddle,
  input  logic                      i_mode,
  input  logic                      i_inverse,
  input  logic                      i_scale,
  input  logic [TAG_WIDTH-1:0]      i_tag,
  output logic                      o_valid,
  input  logic                      i_out_ready,
  output logic [2*DATA_WIDTH-1:0]   o_data_a,
  output logic [2*DATA_WIDTH-1:0]   o_data_b,
  output logic [TAG_WIDTH-1:0]      o_tag,
  output logic                      o_overflow,
  output logic                      o_ovf_sticky,
  input  logic                      i_clear_ovf
);
  localparam int DW = DATA_WIDTH;
  localparam int TW = TWIDDLE_WIDTH;
  localparam int AW = DW + 1;
  localparam int MW = DW + TW + 2;
  localparam int RW = DW + 3;
  localparam int XW = DW + 4;
  localparam logic signed [TW-1:0] WMIN = {1'b1, {(TW-1){1'b0}}};
  localparam logic signed [TW-1:0] WMAX = {1'b0, {(TW-1){1'b1}}};
  localparam logic signed [MW-1:0] RND  = {{(MW-TW+1){1'b0}}, 1'b1, {(TW-2){1'b0}}};
  localparam logic signed [XW-1:0] SMAX = {{(XW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [XW-1:0] SMIN = {{(XW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  // Optional floor halving, then clamp to the output range; MSB flags a clamp
  function automatic logic [DW:0] sat(input logic signed [XW-1:0] x, input logic s);
    logic signed [XW-1:0] y;
    y = s ? (x >>> 1) : x;
    return (y > SMAX) ? {1'b1, DW'(SMAX)} : (y < SMIN) ? {1'b1, DW'(SMIN)} : {1'b0, DW'(y)};
  endfunction

  logic en;
  assign en         = !o_valid || i_out_ready;
  assign o_in_ready = en && !reset;

  logic                     v1_q, m1_q, inv1_q, s1_q;
  logic [2*DW-1:0]          a1_q, b1_q;
  logic [2*TW-1:0]          w1_q;
  logic [TAG_WIDTH-1:0]     t1_q;
  logic                     v2_q, m2_q, s2_q;
  logic signed [AW-1:0]     ar2_q, ai2_q, br2_q, bi2_q;
  logic signed [TW-1:0]     wr2_q, wi2_q;
  logic [TAG_WIDTH-1:0]     t2_q;
  logic                     v3_q, m3_q, s3_q;
  logic signed [AW-1:0]     ar3_q, ai3_q;
  logic signed [RW-1:0]     tr3_q, ti3_q;
  logic [TAG_WIDTH-1:0]     t3_q;
  logic                     v4_q, s4_q;
  logic signed [XW-1:0]     pr4_q, pi4_q, qr4_q, qi4_q;
  logic [TAG_WIDTH-1:0]     t4_q;
  logic                     vo_q, ovf_q, sticky_q;
  logic [2*DW-1:0]          da_q, db_q;
  logic [TAG_WIDTH-1:0]     to_q;

  // S1: capture operands and per-transaction controls
  always_ff @(posedge clk)
    if (reset) begin
      v1_q   <= 1'b0;
      m1_q   <= 1'b0;
      inv1_q <= 1'b0;
      s1_q   <= 1'b0;
      a1_q   <= '0;
      b1_q   <= '0;
      w1_q   <= '0;
      t1_q   <= '0;
    end else if (en) begin
      v1_q   <= i_valid;
      m1_q   <= i_mode;
      inv1_q <= i_inverse;
      s1_q   <= i_scale;
      a1_q   <= i_data_a;
      b1_q   <= i_data_b;
      w1_q   <= i_twiddle;
      t1_q   <= i_tag;
    end

  logic signed [DW-1:0] ar1, ai1, br1, bi1;
  logic signed [TW-1:0] wr1, wi1, wi2_d;
  logic signed [AW-1:0] ar2_d, ai2_d, br2_d, bi2_d;
  assign ar1   = a1_q[2*DW-1:DW];
  assign ai1   = a1_q[DW-1:0];
  assign br1   = b1_q[2*DW-1:DW];
  assign bi1   = b1_q[DW-1:0];
  assign wr1   = w1_q[2*TW-1:TW];
  assign wi1   = w1_q[TW-1:0];
  assign wi2_d = !inv1_q ? wi1 : (wi1 == WMIN) ? WMAX : -wi1;
  assign ar2_d = m1_q ? AW'(ar1) + AW'(br1) : AW'(ar1);
  assign ai2_d = m1_q ? AW'(ai1) + AW'(bi1) : AW'(ai1);
  assign br2_d = m1_q ? AW'(ar1) - AW'(br1) : AW'(br1);
  assign bi2_d = m1_q ? AW'(ai1) - AW'(bi1) : AW'(bi1);

  // S2: DIF pre-add/sub; the B slot always carries the multiplier operand
  always_ff @(posedge clk)
    if (reset) begin
      v2_q  <= 1'b0;
      m2_q  <= 1'b0;
      s2_q  <= 1'b0;
      ar2_q <= '0;
      ai2_q <= '0;
      br2_q <= '0;
      bi2_q <= '0;
      wr2_q <= '0;
      wi2_q <= '0;
      t2_q  <= '0;
    end else if (en) begin
      v2_q  <= v1_q;
      m2_q  <= m1_q;
      s2_q  <= s1_q;
      ar2_q <= ar2_d;
      ai2_q <= ai2_d;
      br2_q <= br2_d;
      bi2_q <= bi2_d;
      wr2_q <= wr1;
      wi2_q <= wi2_d;
      t2_q  <= t1_q;
    end

  logic signed [MW-1:0] pr_w, pi_w;
  logic signed [RW-1:0] tr3_d, ti3_d;
  assign pr_w  = MW'(br2_q) * MW'(wr2_q) - MW'(bi2_q) * MW'(wi2_q) + RND;
  assign pi_w  = MW'(br2_q) * MW'(wi2_q) + MW'(bi2_q) * MW'(wr2_q) + RND;
  assign tr3_d = RW'(pr_w >>> (TW - 1));
  assign ti3_d = RW'(pi_w >>> (TW - 1));

  // S3: full-precision complex multiply with round-half-up
  always_ff @(posedge clk)
    if (reset) begin
      v3_q  <= 1'b0;
      m3_q  <= 1'b0;
      s3_q  <= 1'b0;
      ar3_q <= '0;
      ai3_q <= '0;
      tr3_q <= '0;
      ti3_q <= '0;
      t3_q  <= '0;
    end else if (en) begin
      v3_q  <= v2_q;
      m3_q  <= m2_q;
      s3_q  <= s2_q;
      ar3_q <= ar2_q;
      ai3_q <= ai2_q;
      tr3_q <= tr3_d;
      ti3_q <= ti3_d;
      t3_q  <= t2_q;
    end

  logic signed [XW-1:0] pr4_d, pi4_d, qr4_d, qi4_d;
  assign pr4_d = m3_q ? XW'(ar3_q) : XW'(ar3_q) + XW'(tr3_q);
  assign pi4_d = m3_q ? XW'(ai3_q) : XW'(ai3_q) + XW'(ti3_q);
  assign qr4_d = m3_q ? XW'(tr3_q) : XW'(ar3_q) - XW'(tr3_q);
  assign qi4_d = m3_q ? XW'(ti3_q) : XW'(ai3_q) - XW'(ti3_q);

  // S4: DIT post-add/sub at full width
  always_ff @(posedge clk)
    if (reset) begin
      v4_q  <= 1'b0;
      s4_q  <= 1'b0;
      pr4_q <= '0;
      pi4_q <= '0;
      qr4_q <= '0;
      qi4_q <= '0;
      t4_q  <= '0;
    end else if (en) begin
      v4_q  <= v3_q;
      s4_q  <= s3_q;
      pr4_q <= pr4_d;
      pi4_q <= pi4_d;
      qr4_q <= qr4_d;
      qi4_q <= qi4_d;
      t4_q  <= t3_q;
    end

  logic [DW:0] sar, sai, sbr, sbi;
  assign sar = sat(pr4_q, s4_q);
  assign sai = sat(pi4_q, s4_q);
  assign sbr = sat(qr4_q, s4_q);
  assign sbi = sat(qi4_q, s4_q);

  // Output register: scaled, saturated results held while downstream stalls
  always_ff @(posedge clk)
    if (reset) begin
      vo_q  <= 1'b0;
      ovf_q <= 1'b0;
      da_q  <= '0;
      db_q  <= '0;
      to_q  <= '0;
    end else if (en) begin
      vo_q  <= v4_q;
      ovf_q <= v4_q && (sar[DW] || sai[DW] || sbr[DW] || sbi[DW]);
      da_q  <= {sar[DW-1:0], sai[DW-1:0]};
      db_q  <= {sbr[DW-1:0], sbi[DW-1:0]};
      to_q  <= t4_q;
    end

  // Sticky overflow: a delivered overflow beats a simultaneous clear
  always_ff @(posedge clk)
    sticky_q <= reset ? 1'b0 : (o_valid && i_out_ready && o_overflow) ? 1'b1 : i_clear_ovf ? 1'b0 : sticky_q;

  assign o_valid      = vo_q;
  assign o_overflow   = ovf_q;
  assign o_data_a     = da_q;
  assign o_data_b     = db_q;
  assign o_tag        = to_q;
  assign o_ovf_sticky = sticky_q;
endmodule
